// File: rtl/move_scheduler_if.sv
// Segment write port between the SPI command handler (master) and the move scheduler (slave).
interface move_scheduler_if #(
    parameter int unsigned DUR_W = 32,
    parameter int unsigned INC_W = 64
);
    logic                    wr_valid;
    logic                    wr_ready;
    logic                    wr_dir;
    logic [DUR_W-1:0]        wr_duration;
    logic signed [INC_W-1:0] wr_increment;
    logic signed [INC_W-1:0] wr_incinc;

    modport master (
        output wr_valid, wr_dir, wr_duration, wr_increment, wr_incinc,
        input  wr_ready
    );

    modport slave (
        input  wr_valid, wr_dir, wr_duration, wr_increment, wr_incinc,
        output wr_ready
    );
endinterface

// File: rtl/move_scheduler.sv
// Segment FIFO plus sequencer: pops segments onto the DDA datapath bus, divides the clock into
// tick strobes and counts each segment's duration down.
module move_scheduler #(
    parameter int unsigned BUFFER_BITS = 2,
    parameter int unsigned DUR_W       = 32,
    parameter int unsigned INC_W       = 64
) (
    input  logic                    clk,
    input  logic                    resetn,
    move_scheduler_if.slave         wr,
    input  logic [7:0]              clock_divisor,
    input  logic                    enable,
    input  logic                    abort,
    output logic                    seg_dir,
    output logic signed [INC_W-1:0] seg_increment,
    output logic signed [INC_W-1:0] seg_incinc,
    output logic                    load,
    output logic                    tick,
    output logic                    busy,
    output logic [BUFFER_BITS:0]    level,
    output logic                    buffer_dtr,
    output logic                    move_done
);
    localparam int unsigned DEPTH = 1 << BUFFER_BITS;
    localparam logic [BUFFER_BITS:0] FULL_LEVEL = (BUFFER_BITS + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

    state_e                   state_q;
    logic [BUFFER_BITS-1:0]   wr_ptr_q;
    logic [BUFFER_BITS-1:0]   rd_ptr_q;
    logic [BUFFER_BITS:0]     level_q;
    logic [7:0]               divcnt_q;
    logic [7:0]               div_q;
    logic [DUR_W-1:0]         remaining_q;

    logic                     dir_mem    [DEPTH];
    logic [DUR_W-1:0]         dur_mem    [DEPTH];
    logic signed [INC_W-1:0]  inc_mem    [DEPTH];
    logic signed [INC_W-1:0]  incinc_mem [DEPTH];

    logic full;
    logic push;
    logic tick_now;
    logic seg_end;
    logic pop;

    assign full     = (level_q == FULL_LEVEL);
    assign push     = wr.wr_valid && !full && !abort;
    assign tick_now = (state_q == StRun) && enable && (divcnt_q == 8'd0);
    assign seg_end  = tick_now && (remaining_q == '0);
    // A pop is the transition into StLoad, from idle or straight out of a finished segment.
    assign pop      = !abort && (level_q != '0) && ((state_q == StIdle) || seg_end);

    assign wr.wr_ready = !full;
    assign buffer_dtr  = !full;
    assign level       = level_q;
    assign load        = (state_q == StLoad);
    assign busy        = (state_q != StIdle);
    assign tick        = tick_now;

    always_ff @(posedge clk) begin
        if (resetn && push) begin
            dir_mem[wr_ptr_q]    <= wr.wr_dir;
            dur_mem[wr_ptr_q]    <= wr.wr_duration;
            inc_mem[wr_ptr_q]    <= wr.wr_increment;
            incinc_mem[wr_ptr_q] <= wr.wr_incinc;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= StIdle;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            divcnt_q      <= '0;
            div_q         <= '0;
            remaining_q   <= '0;
            seg_dir       <= 1'b0;
            seg_increment <= '0;
            seg_incinc    <= '0;
            move_done     <= 1'b0;
        end else if (abort) begin
            // seg_* and move_done are deliberately left alone.
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + BUFFER_BITS'(1);
            end
            level_q <= level_q + (BUFFER_BITS + 1)'(push) - (BUFFER_BITS + 1)'(pop);

            case (state_q)
                StIdle: begin
                    if (pop) begin
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    divcnt_q <= clock_divisor;
                    div_q    <= clock_divisor;
                    state_q  <= StRun;
                end
                StRun: begin
                    if (enable) begin
                        if (divcnt_q == 8'd0) begin
                            divcnt_q <= div_q;
                            if (remaining_q == '0) begin
                                move_done <= ~move_done;
                                state_q   <= pop ? StLoad : StIdle;
                            end else begin
                                remaining_q <= remaining_q - DUR_W'(1);
                            end
                        end else begin
                            divcnt_q <= divcnt_q - 8'd1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (pop) begin
                seg_dir       <= dir_mem[rd_ptr_q];
                seg_increment <= inc_mem[rd_ptr_q];
                seg_incinc    <= incinc_mem[rd_ptr_q];
                remaining_q   <= dur_mem[rd_ptr_q];
                rd_ptr_q      <= rd_ptr_q + BUFFER_BITS'(1);
            end
        end
    end
endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench for move_scheduler: load/tick/done timing, FIFO full, pause, abort and reset.
module tb_move_scheduler;
    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic [7:0]        clock_divisor = 8'd0;
    logic              enable = 1'b1;
    logic              abort = 1'b0;
    logic              seg_dir;
    logic signed [63:0] seg_increment;
    logic signed [63:0] seg_incinc;
    logic              load;
    logic              tick;
    logic              busy;
    logic [2:0]        level;
    logic              buffer_dtr;
    logic              move_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ticks[$];
    int loads[$];
    int dones[$];
    int busy_falls[$];
    logic md_prev = 1'b0;
    logic busy_prev = 1'b0;

    move_scheduler_if #(.DUR_W(32), .INC_W(64)) wif ();

    move_scheduler #(.BUFFER_BITS(2), .DUR_W(32), .INC_W(64)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .wr           (wif),
        .clock_divisor(clock_divisor),
        .enable       (enable),
        .abort        (abort),
        .seg_dir      (seg_dir),
        .seg_increment(seg_increment),
        .seg_incinc   (seg_incinc),
        .load         (load),
        .tick         (tick),
        .busy         (busy),
        .level        (level),
        .buffer_dtr   (buffer_dtr),
        .move_done    (move_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Event log sampled mid-cycle, indexed by cycle number.
    always @(negedge clk) begin
        if (tick) ticks.push_back(cyc);
        if (load) loads.push_back(cyc);
        if (move_done !== md_prev) dones.push_back(cyc);
        if (busy_prev && !busy) busy_falls.push_back(cyc);
        md_prev   <= move_done;
        busy_prev <= busy;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic clear_log();
        ticks.delete();
        loads.delete();
        dones.delete();
        busy_falls.delete();
    endtask

    task automatic push(input logic dir, input logic [31:0] d, input logic [63:0] inc,
                        input logic [63:0] incinc);
        wif.wr_valid     = 1'b1;
        wif.wr_dir       = dir;
        wif.wr_duration  = d;
        wif.wr_increment = inc;
        wif.wr_incinc    = incinc;
        step();
        wif.wr_valid = 1'b0;
    endtask

    task automatic wait_load(input string tag, output int lc);
        bit found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (load) begin
                found = 1'b1;
                break;
            end
            step();
        end
        lc = cyc;
        chk(tag, 64'(found), 64'd1);
    endtask

    task automatic chk_reset_values(input string pfx);
        chk({pfx, "_wr_ready"}, 64'(wif.wr_ready), 64'd1);
        chk({pfx, "_buffer_dtr"}, 64'(buffer_dtr), 64'd1);
        chk({pfx, "_load"}, 64'(load), 64'd0);
        chk({pfx, "_tick"}, 64'(tick), 64'd0);
        chk({pfx, "_busy"}, 64'(busy), 64'd0);
        chk({pfx, "_level"}, 64'(level), 64'd0);
        chk({pfx, "_move_done"}, 64'(move_done), 64'd0);
        chk({pfx, "_seg_dir"}, 64'(seg_dir), 64'd0);
        chk({pfx, "_seg_increment"}, seg_increment, 64'd0);
        chk({pfx, "_seg_incinc"}, seg_incinc, 64'd0);
    endtask

    initial begin
        int p;
        int l;
        logic md_before;

        wif.wr_valid     = 1'b0;
        wif.wr_dir       = 1'b0;
        wif.wr_duration  = '0;
        wif.wr_increment = '0;
        wif.wr_incinc    = '0;
        step();
        step();
        resetn = 1'b1;
        chk_reset_values("reset");

        // Single segment D=3, div=2.
        clock_divisor = 8'd2;
        clear_log();
        p = cyc;
        push(1'b1, 32'd3, 64'd5, 64'd0);
        chk("t1_level_after_push", 64'(level), 64'd1);
        step();
        chk("t1_load_at_p2", 64'(load), 64'd1);
        chk("t1_load_cycle", 64'(cyc), 64'(p + 2));
        chk("t1_seg_dir", 64'(seg_dir), 64'd1);
        chk("t1_seg_increment", seg_increment, 64'd5);
        chk("t1_seg_incinc", seg_incinc, 64'd0);
        l = cyc;
        repeat (15) step();
        chk("t1_tick_count", 64'(ticks.size()), 64'd4);
        for (int i = 0; i < 4; i++) chk("t1_tick_time", 64'(qget(ticks, i)), 64'(l + 3 * (i + 1)));
        chk("t1_done_time", 64'(qget(dones, 0)), 64'(l + 13));
        chk("t1_busy_fall", 64'(qget(busy_falls, 0)), 64'(l + 13));
        chk("t1_move_done", 64'(move_done), 64'd1);

        // FIFO full while a long segment runs.
        clock_divisor = 8'd0;
        push(1'b0, 32'd100, 64'd1, 64'd0);
        wait_load("t2_long_load", l);
        push(1'b0, 32'd0, 64'd11, 64'd0);
        push(1'b0, 32'd0, 64'd12, 64'd0);
        push(1'b0, 32'd0, 64'd13, 64'd0);
        push(1'b0, 32'd0, 64'd14, 64'd0);
        chk("t2_level_full", 64'(level), 64'd4);
        chk("t2_wr_ready_full", 64'(wif.wr_ready), 64'd0);
        chk("t2_dtr_full", 64'(buffer_dtr), 64'd0);
        push(1'b1, 32'd0, 64'd15, 64'd0);
        chk("t2_level_after_5th", 64'(level), 64'd4);
        wait_load("t2_next_load", l);
        chk("t2_level_after_pop", 64'(level), 64'd3);
        chk("t2_wr_ready_after_pop", 64'(wif.wr_ready), 64'd1);
        chk("t2_popped_inc", seg_increment, 64'd11);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t2_abort_level", 64'(level), 64'd0);
        chk("t2_abort_busy", 64'(busy), 64'd0);
        repeat (3) step();

        // Two back-to-back D=0, div=0 segments.
        clear_log();
        md_before = move_done;
        push(1'b0, 32'd0, 64'd21, 64'd0);
        push(1'b1, 32'd0, 64'd22, 64'd0);
        wait_load("t3_load", l);
        repeat (6) step();
        chk("t3_load0", 64'(qget(loads, 0)), 64'(l));
        chk("t3_load1", 64'(qget(loads, 1)), 64'(l + 2));
        chk("t3_tick0", 64'(qget(ticks, 0)), 64'(l + 1));
        chk("t3_tick1", 64'(qget(ticks, 1)), 64'(l + 3));
        chk("t3_tick_count", 64'(ticks.size()), 64'd2);
        chk("t3_done0", 64'(qget(dones, 0)), 64'(l + 2));
        chk("t3_done1", 64'(qget(dones, 1)), 64'(l + 4));
        chk("t3_move_done", 64'(move_done), 64'(md_before));
        chk("t3_busy_fall", 64'(qget(busy_falls, 0)), 64'(l + 4));

        // D=2, div=1 with a 5-cycle pause after the first tick.
        clear_log();
        clock_divisor = 8'd1;
        push(1'b0, 32'd2, 64'd31, 64'd0);
        wait_load("t4_load", l);
        repeat (3) step();
        enable = 1'b0;
        repeat (5) step();
        enable = 1'b1;
        repeat (6) step();
        chk("t4_tick0", 64'(qget(ticks, 0)), 64'(l + 2));
        chk("t4_tick1", 64'(qget(ticks, 1)), 64'(l + 4 + 5));
        chk("t4_tick2", 64'(qget(ticks, 2)), 64'(l + 6 + 5));
        chk("t4_tick_count", 64'(ticks.size()), 64'd3);
        chk("t4_done", 64'(qget(dones, 0)), 64'(l + 12));

        // Abort mid-segment with two queued entries and a push in the abort cycle.
        clock_divisor = 8'd0;
        push(1'b1, 32'd50, 64'h33, 64'd0);
        wait_load("t5_load", l);
        push(1'b0, 32'd0, 64'd41, 64'd0);
        push(1'b0, 32'd0, 64'd42, 64'd0);
        repeat (3) step();
        chk("t5_level_queued", 64'(level), 64'd2);
        md_before = move_done;
        abort = 1'b1;
        wif.wr_valid = 1'b1;
        wif.wr_increment = 64'h99;
        step();
        abort = 1'b0;
        wif.wr_valid = 1'b0;
        chk("t5_abort_level", 64'(level), 64'd0);
        chk("t5_abort_busy", 64'(busy), 64'd0);
        chk("t5_abort_tick", 64'(tick), 64'd0);
        chk("t5_seg_hold", seg_increment, 64'h33);
        chk("t5_move_done_hold", 64'(move_done), 64'(md_before));
        clear_log();
        repeat (10) step();
        chk("t5_no_ticks", 64'(ticks.size()), 64'd0);
        chk("t5_no_loads", 64'(loads.size()), 64'd0);
        chk("t5_level_still_empty", 64'(level), 64'd0);

        // Reset during RUN with a full FIFO.
        push(1'b1, 32'd50, 64'd51, 64'd52);
        wait_load("t6_load", l);
        push(1'b0, 32'd0, 64'd61, 64'd0);
        push(1'b0, 32'd0, 64'd62, 64'd0);
        push(1'b0, 32'd0, 64'd63, 64'd0);
        push(1'b0, 32'd0, 64'd64, 64'd0);
        chk("t6_level_full", 64'(level), 64'd4);
        resetn = 1'b0;
        wif.wr_valid = 1'b1;
        step();
        resetn = 1'b1;
        wif.wr_valid = 1'b0;
        chk_reset_values("t6_reset");
        p = cyc;
        push(1'b0, 32'd1, 64'd77, 64'd3);
        wait_load("t6_reload", l);
        chk("t6_reload_cycle", 64'(l), 64'(p + 2));
        chk("t6_reload_inc", seg_increment, 64'd77);
        chk("t6_reload_incinc", seg_incinc, 64'd3);
        chk("t6_reload_level", 64'(level), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
